// File: rtl/serial_addsub_unit.sv
// Digit-serial WIDTH-bit adder/subtractor: one SLICE-bit slice per clock with a registered ripple carry,
// behind a valid/ready operand/result handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1; waiting for in_valid, last result held on outputs
// CALC  | one slice per clock, LSB slice first; r_cnt counts down to 0
// DONE  | out_valid=1; result held until out_ready
module serial_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("serial_addsub_unit: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // B already conditionally inverted (Beff)
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;

    logic [CW-1:0]    w_idx;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE:0]   w_sum;
    logic             w_last;

    assign w_last    = (r_cnt == '0);
    assign w_idx     = CW'(N - 1) - r_cnt;
    assign w_a_slice = r_a[w_idx*SLICE +: SLICE];
    assign w_b_slice = r_b[w_idx*SLICE +: SLICE];
    assign w_sum     = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_carry};

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CALC;
            S_CALC:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= data_operandA;
                        r_b     <= data_operandB ^ {WIDTH{ctrl_sub}};
                        r_carry <= ctrl_sub;
                        r_cnt   <= CW'(N - 1);
                    end
                end
                S_CALC: begin
                    r_result[w_idx*SLICE +: SLICE] <= w_sum[SLICE-1:0];
                    r_carry <= w_sum[SLICE];
                    r_cnt   <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_carry_out <= w_sum[SLICE];
                        r_overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_sum[SLICE-1] != r_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign data_result = r_result;
    assign carry_out   = r_carry_out;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: vector table, hand-written corner sequences
// and randomized operations against an arithmetic reference model.
module tb_serial_addsub_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    serial_addsub_unit #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_sub      (ctrl_sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .carry_out     (carry_out),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_r;
        logic        exp_c;
        logic        exp_v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, independent of any slicing.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r  = 32'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = 32'(ua + ub);
            c  = ((ua + ub) >= 64'sh1_0000_0000);
            sr = sa + sb;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one op, wait for the result, consume it after 'hold' extra cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input int hold,
                         output logic [31:0] r, output logic c, output logic v, output int lat);
        check("in_ready_before_op", {63'd0, in_ready}, 64'd1);
        in_valid      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        ctrl_sub      = sub;
        tick();
        in_valid      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_sub      = ~sub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 20 cycles");
        end
        r = data_result;
        c = carry_out;
        v = overflow;
        for (int k = 0; k < hold; k++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [31:0] r, er, held;
    logic        c, v, ec, ev;
    int          lat;
    logic        bp_ok;

    initial begin
        resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b0; ctrl_sub = 1'b0;
        data_operandA = 32'h1234_5678; data_operandB = 32'h1;

        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0});

        // Reset held two cycles with in_valid asserted
        tick(); tick();
        resetn = 1'b1; in_valid = 1'b0;
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result",    {32'd0, data_result}, 64'd0);
        check("reset_carry",     {63'd0, carry_out}, 64'd0);
        check("reset_overflow",  {63'd0, overflow},  64'd0);
        for (int k = 0; k < 6; k++) tick();
        check("reset_no_op_started", {62'd0, out_valid, in_ready}, 64'd1);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, i % 3, r, c, v, lat);
            check($sformatf("vec%0d_result", i),   {32'd0, r}, {32'd0, vecs[i].exp_r});
            check($sformatf("vec%0d_carry", i),    {63'd0, c}, {63'd0, vecs[i].exp_c});
            check($sformatf("vec%0d_overflow", i), {63'd0, v}, {63'd0, vecs[i].exp_v});
            check($sformatf("vec%0d_latency", i),  64'(lat), 64'(LAT));
        end

        // Power-of-two doubling crosses every slice boundary
        for (int i = 0; i <= 30; i++) begin
            do_op(32'd1 << i, 32'd1 << i, 1'b0, 0, r, c, v, lat);
            check($sformatf("pow2_%0d_result", i),  {32'd0, r}, {32'd0, 32'd1 << (i + 1)});
            check($sformatf("pow2_%0d_latency", i), 64'(lat), 64'(LAT));
        end

        // Backpressure: result held while new operands are offered
        do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 0, r, c, v, lat);
        in_valid = 1'b1; data_operandA = 32'h1111_1111; data_operandB = 32'h2222_2222; ctrl_sub = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        held = data_result;
        model(32'h1111_1111, 32'h2222_2222, 1'b0, er, ec, ev);
        check("bp_result", {32'd0, held}, {32'd0, er});
        in_valid = 1'b1; data_operandA = 32'h5555_5555; data_operandB = 32'h0000_0003; ctrl_sub = 1'b1;
        bp_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (data_result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bp_ok = 1'b0;
            data_operandA = $urandom;
        end
        check("bp_hold_stable", {63'd0, bp_ok}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", {62'd0, out_valid, in_ready}, 64'd1);
        tick();
        check("bp_single_transition", {62'd0, out_valid, in_ready}, 64'd1);
        do_op(32'h5555_5555, 32'h0000_0003, 1'b1, 0, r, c, v, lat);
        check("bp_next_result", {32'd0, r}, 64'h5555_5552);

        // Reset during the second CALC cycle
        in_valid = 1'b1; data_operandA = 32'h1234_5678; data_operandB = 32'h1111_1111; ctrl_sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_idle",     {62'd0, out_valid, in_ready}, 64'd1);
        check("midrst_result",   {32'd0, data_result}, 64'd0);
        check("midrst_flags",    {62'd0, carry_out, overflow}, 64'd0);
        bp_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b0) bp_ok = 1'b0;
        end
        check("midrst_no_valid_pulse", {63'd0, bp_ok}, 64'd1);
        do_op(32'd1, 32'd1, 1'b0, 0, r, c, v, lat);
        check("midrst_then_1plus1", {32'd0, r}, 64'd2);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = $urandom;
            rb = (i % 4 == 0) ? ~ra + 32'($urandom_range(0, 2)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, ec, ev);
            do_op(ra, rb, rs, $urandom_range(0, 3), r, c, v, lat);
            check($sformatf("rand%0d_result", i), {32'd0, r}, {32'd0, er});
            check($sformatf("rand%0d_flags", i),  {62'd0, c, v}, {62'd0, ec, ev});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
